// File: rtl/dtmr_sched.sv
// Dynamic-TMR scheduler: runs one primary replica in simplex and wakes/seeds the spares to vote on request.
// Optional macro DTMR_FAULT_DROP_EN: flagged replicas are disabled, excluded from voting and from primary choice.
module dtmr_sched #(
    parameter int CMD_L    = 4,
    parameter int SYNC_CYC = 3,
    parameter int FAULT_TH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tmr_req,
    input  logic [CMD_L-1:0] speed_r0,
    input  logic [CMD_L-1:0] speed_r1,
    input  logic [CMD_L-1:0] speed_r2,
    input  logic [CMD_L-1:0] dir_r0,
    input  logic [CMD_L-1:0] dir_r1,
    input  logic [CMD_L-1:0] dir_r2,
    output logic [2:0]       en_r,
    output logic [2:0]       state_r,
    output logic [CMD_L-1:0] speed_cmd_prev,
    output logic [CMD_L-1:0] dir_cmd_prev,
    output logic [CMD_L-1:0] speed_cmd_o,
    output logic [CMD_L-1:0] dir_cmd_o,
    output logic             tmr_active,
    output logic             no_maj,
    output logic [2:0]       fault
);
    localparam int W   = 2 * CMD_L;
    localparam int CW  = $clog2(FAULT_TH + 1);
    localparam int WCW = $clog2(SYNC_CYC);
    localparam logic [CW-1:0]  TH        = CW'(FAULT_TH);
    localparam logic [WCW-1:0] WAKE_LAST = WCW'(SYNC_CYC - 1);

    localparam logic [1:0] S_SIMPLEX = 2'd0;
    localparam logic [1:0] S_WAKE    = 2'd1;
    localparam logic [1:0] S_TMR     = 2'd2;

    logic [1:0]     fsm, fsm_n;
    logic [WCW-1:0] wake_cnt, wake_cnt_n;
    logic [CW-1:0]  mm_cnt   [3];
    logic [CW-1:0]  mm_cnt_n [3];
    logic [W-1:0]   word     [3];
    logic [W-1:0]   word_p, winner, cmd_q, cmd_n, prev_q, prev_n;
    logic [2:0]     fault_n, healthy, healthy_n, en_n, st_n;
    logic [1:0]     p, p_n;
    logic           a01, a02, a12, has_win, no_maj_n, can_tmr;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b001;
        endcase
    endfunction

    assign word[0] = {speed_r0, dir_r0};
    assign word[1] = {speed_r1, dir_r1};
    assign word[2] = {speed_r2, dir_r2};

`ifdef DTMR_FAULT_DROP_EN
    // All-flagged falls back to treating every replica as usable.
    assign healthy   = (fault == 3'b111) ? 3'b111 : ~fault;
    assign healthy_n = (fault_n == 3'b111) ? 3'b111 : ~fault_n;
    assign can_tmr   = (healthy[0] & healthy[1]) | (healthy[0] & healthy[2]) | (healthy[1] & healthy[2]);
    assign p_n       = (fsm_n != S_SIMPLEX) ? p :
                       healthy_n[0] ? 2'd0 : healthy_n[1] ? 2'd1 : 2'd2;

    always_ff @(posedge clk) begin
        if (rst) p <= 2'd0;
        else     p <= p_n;
    end
`else
    assign healthy   = 3'b111;
    assign healthy_n = 3'b111;
    assign can_tmr   = 1'b1;
    assign p         = 2'd0;
    assign p_n       = 2'd0;
`endif

    always_comb begin
        case (p)
            2'd1:    word_p = word[1];
            2'd2:    word_p = word[2];
            default: word_p = word[0];
        endcase
    end

    assign a01     = healthy[0] & healthy[1] & (word[0] == word[1]);
    assign a02     = healthy[0] & healthy[2] & (word[0] == word[2]);
    assign a12     = healthy[1] & healthy[2] & (word[1] == word[2]);
    assign has_win = a01 | a02 | a12;
    assign winner  = (a01 | a02) ? word[0] : word[1];

    always_comb begin
        fsm_n      = fsm;
        wake_cnt_n = wake_cnt;
        cmd_n      = word_p;
        prev_n     = prev_q;
        no_maj_n   = 1'b0;
        fault_n    = fault;
        mm_cnt_n   = mm_cnt;
        case (fsm)
            S_SIMPLEX: begin
                prev_n = word_p;
                if (tmr_req && can_tmr) begin
                    fsm_n      = S_WAKE;
                    wake_cnt_n = '0;
                end
            end
            S_WAKE: begin
                // Snapshot stays frozen so the spares load a stable value.
                if (!tmr_req)                   fsm_n = S_SIMPLEX;
                else if (wake_cnt == WAKE_LAST) fsm_n = S_TMR;
                else                            wake_cnt_n = wake_cnt + 1'b1;
            end
            S_TMR: begin
                if (!tmr_req) begin
                    fsm_n = S_SIMPLEX;
                end else if (has_win) begin
                    cmd_n  = winner;
                    prev_n = winner;
                    for (int i = 0; i < 3; i++) begin
                        if (word[i] == winner)  mm_cnt_n[i] = '0;
                        else if (mm_cnt[i] != TH) mm_cnt_n[i] = mm_cnt[i] + 1'b1;
                        if (mm_cnt_n[i] == TH) fault_n[i] = 1'b1;
                    end
                end else begin
                    cmd_n    = cmd_q;
                    no_maj_n = 1'b1;
                end
            end
            default: fsm_n = S_SIMPLEX;
        endcase
    end

    assign en_n = ((fsm_n == S_SIMPLEX) ? onehot(p_n) : 3'b111) & healthy_n;
    assign st_n = (fsm_n == S_SIMPLEX) ? 3'b000 : ~onehot(p);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= S_SIMPLEX;
            wake_cnt   <= '0;
            for (int i = 0; i < 3; i++) mm_cnt[i] <= '0;
            cmd_q      <= '0;
            prev_q     <= '0;
            en_r       <= 3'b001;
            state_r    <= 3'b000;
            tmr_active <= 1'b0;
            no_maj     <= 1'b0;
            fault      <= 3'b000;
        end else begin
            fsm        <= fsm_n;
            wake_cnt   <= wake_cnt_n;
            for (int i = 0; i < 3; i++) mm_cnt[i] <= mm_cnt_n[i];
            cmd_q      <= cmd_n;
            prev_q     <= prev_n;
            en_r       <= en_n;
            state_r    <= st_n;
            tmr_active <= (fsm_n == S_TMR);
            no_maj     <= no_maj_n;
            fault      <= fault_n;
        end
    end

    assign speed_cmd_o    = cmd_q[W-1:CMD_L];
    assign dir_cmd_o      = cmd_q[CMD_L-1:0];
    assign speed_cmd_prev = prev_q[W-1:CMD_L];
    assign dir_cmd_prev   = prev_q[CMD_L-1:0];
endmodule
